// File: rtl/uart_axil_regs_if.sv
// AXI-Lite bus interface used by the UART register block and the masters that drive it.
interface taxi_axil_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport wr_slv (input awaddr, awvalid, wdata, wstrb, wvalid, bready,
                    output awready, wready, bresp, bvalid);
    modport wr_mst (output awaddr, awvalid, wdata, wstrb, wvalid, bready,
                    input awready, wready, bresp, bvalid);
    modport rd_slv (input araddr, arvalid, rready,
                    output arready, rdata, rresp, rvalid);
    modport rd_mst (output araddr, arvalid, rready,
                    input arready, rdata, rresp, rvalid);
endinterface

// File: rtl/uart_axil_regs.sv
// AXI-Lite register file for a UART: CR1, SR, BRR, RDR, TDR.
// Define UART_AXIL_WSTRB_EN to honour wstrb byte lanes; otherwise every write is full-word.
module uart_axil_regs #(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter logic [15:0] BRR_RST = 16'h0364
) (
    input  logic        Clk,
    input  logic        Rst_n,
    taxi_axil_if.wr_slv wr_axil,
    taxi_axil_if.rd_slv rd_axil,
    output logic [2:0]  cr1,
    output logic [15:0] brr,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    logic              live_reg;
    logic              aw_full_reg, w_full_reg;
    logic [2:0]        aw_idx_reg;
    logic [15:0]       w_data_reg;
    logic              bvalid_reg;
    logic [1:0]        bresp_reg;
    rd_state_t         rd_state_reg;
    logic              arready_reg, rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [1:0]        rresp_reg;
    logic [2:0]        cr1_reg;
    logic [15:0]       brr_reg;
    logic [7:0]        tx_data_reg, rdr_reg;
    logic              tx_wr_reg, rxne_reg, ore_reg;

    logic              awready_int, wready_int, aw_hs, w_hs, ar_hs, commit;
    logic              sr_clr, rdr_read, unused_bits;
    logic [1:0]        strb_eff;
    logic [15:0]       wmask;
    logic [2:0]        rd_idx;
    logic [DATA_W-1:0] rd_word;

    function automatic logic unmapped(input logic [2:0] idx);
        return idx[0] & (idx[1] | idx[2]);
    endfunction

`ifdef UART_AXIL_WSTRB_EN
    logic [1:0] w_strb_reg;
    assign strb_eff    = w_strb_reg;
    assign unused_bits = ^{wr_axil.wstrb[3:2], wr_axil.wdata[31:16],
                           wr_axil.awaddr[ADDR_W-1:5], wr_axil.awaddr[1:0],
                           rd_axil.araddr[ADDR_W-1:5], rd_axil.araddr[1:0]};
`else
    assign strb_eff    = 2'b11;
    assign unused_bits = ^{wr_axil.wstrb, wr_axil.wdata[31:16],
                           wr_axil.awaddr[ADDR_W-1:5], wr_axil.awaddr[1:0],
                           rd_axil.araddr[ADDR_W-1:5], rd_axil.araddr[1:0]};
`endif

    // Only lanes 0 and 1 carry live register bits.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign wmask[8*gi +: 8] = {8{strb_eff[gi]}};
    end

    // live_reg holds all readies low until the first edge after reset release.
    assign awready_int = live_reg & ~aw_full_reg;
    assign wready_int  = live_reg & ~w_full_reg;
    assign aw_hs       = wr_axil.awvalid & awready_int;
    assign w_hs        = wr_axil.wvalid & wready_int;
    assign commit      = aw_full_reg & w_full_reg & ~bvalid_reg;
    assign rd_idx      = rd_axil.araddr[4:2];
    assign ar_hs       = rd_axil.arvalid & arready_reg;
    assign rdr_read    = ar_hs & (rd_idx == 3'd4);
    assign sr_clr      = commit & (aw_idx_reg == 3'd1) & strb_eff[0] & w_data_reg[3];

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            3'd0:    rd_word[2:0]  = cr1_reg;
            3'd1:    rd_word[3:0]  = {ore_reg, 1'b0, rxne_reg, ~tx_busy};
            3'd2:    rd_word[15:0] = brr_reg;
            3'd4:    rd_word[7:0]  = rdr_reg;
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            live_reg    <= 1'b0;
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
            aw_idx_reg  <= '0;
            w_data_reg  <= '0;
`ifdef UART_AXIL_WSTRB_EN
            w_strb_reg  <= '0;
`endif
            bvalid_reg  <= 1'b0;
            bresp_reg   <= 2'b00;
            cr1_reg     <= '0;
            brr_reg     <= BRR_RST;
            tx_data_reg <= '0;
            tx_wr_reg   <= 1'b0;
        end else begin
            live_reg  <= 1'b1;
            tx_wr_reg <= 1'b0;
            if (aw_hs) begin
                aw_full_reg <= 1'b1;
                aw_idx_reg  <= wr_axil.awaddr[4:2];
            end
            if (w_hs) begin
                w_full_reg <= 1'b1;
                w_data_reg <= wr_axil.wdata[15:0];
`ifdef UART_AXIL_WSTRB_EN
                w_strb_reg <= wr_axil.wstrb[1:0];
`endif
            end
            if (bvalid_reg && wr_axil.bready)
                bvalid_reg <= 1'b0;
            if (commit) begin
                aw_full_reg <= 1'b0;
                w_full_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= unmapped(aw_idx_reg) ? 2'b10 : 2'b00;
                case (aw_idx_reg)
                    3'd0: cr1_reg <= (cr1_reg & ~wmask[2:0]) | (w_data_reg[2:0] & wmask[2:0]);
                    3'd2: brr_reg <= (brr_reg & ~wmask) | (w_data_reg & wmask);
                    3'd6: if (strb_eff[0]) begin
                        tx_data_reg <= w_data_reg[7:0];
                        tx_wr_reg   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Incoming bytes take priority over both the RDR-read clear and the ORE W1C.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rdr_reg  <= '0;
            rxne_reg <= 1'b0;
            ore_reg  <= 1'b0;
        end else begin
            if (rdr_read)
                rxne_reg <= 1'b0;
            if (sr_clr)
                ore_reg <= 1'b0;
            if (rx_valid) begin
                rdr_reg  <= rx_data;
                rxne_reg <= 1'b1;
                if (rxne_reg)
                    ore_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_state_reg <= RD_IDLE;
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            rresp_reg    <= 2'b00;
        end else begin
            case (rd_state_reg)
                RD_IDLE: begin
                    arready_reg <= 1'b1;
                    if (ar_hs) begin
                        rd_state_reg <= RD_RESP;
                        arready_reg  <= 1'b0;
                        rvalid_reg   <= 1'b1;
                        rdata_reg    <= rd_word;
                        rresp_reg    <= unmapped(rd_idx) ? 2'b10 : 2'b00;
                    end
                end
                RD_RESP: begin
                    if (rd_axil.rready) begin
                        rd_state_reg <= RD_IDLE;
                        rvalid_reg   <= 1'b0;
                        arready_reg  <= 1'b1;
                    end
                end
                default: rd_state_reg <= RD_IDLE;
            endcase
        end
    end

    assign wr_axil.awready = awready_int;
    assign wr_axil.wready  = wready_int;
    assign wr_axil.bvalid  = bvalid_reg;
    assign wr_axil.bresp   = bresp_reg;
    assign rd_axil.arready = arready_reg;
    assign rd_axil.rvalid  = rvalid_reg;
    assign rd_axil.rdata   = rdata_reg;
    assign rd_axil.rresp   = rresp_reg;
    assign cr1             = cr1_reg;
    assign brr             = brr_reg;
    assign tx_data         = tx_data_reg;
    assign tx_wr           = tx_wr_reg;
endmodule

// File: tb/tb_uart_axil_regs.sv
// Randomised bench for uart_axil_regs: transaction-level register model plus per-cycle output compare.
module tb_uart_axil_regs;
    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [2:0]  cr1;
    logic [15:0] brr;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_valid;

    taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) axil ();

    uart_axil_regs dut (
        .Clk(Clk), .Rst_n(Rst_n), .wr_axil(axil), .rd_axil(axil),
        .cr1(cr1), .brr(brr), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    always #5 Clk = ~Clk;

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Register model
    logic [2:0]  m_cr1;
    logic [15:0] m_brr;
    logic [7:0]  m_txd, m_rdr;
    bit          m_rxne, m_ore;
    bit          exp_tx_wr, exp_bvalid, exp_rvalid, cmp_en;
    logic [1:0]  exp_bresp, exp_rresp;
    logic [31:0] exp_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        check_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    endtask

    task automatic model_reset();
        m_cr1 = '0; m_brr = 16'h0364; m_txd = '0; m_rdr = '0; m_rxne = 0; m_ore = 0;
        exp_tx_wr = 0; exp_bvalid = 0; exp_rvalid = 0; exp_bresp = 0; exp_rresp = 0; exp_rdata = 0;
    endtask

    function automatic bit unmapped(input logic [31:0] a);
        return a[4:2] inside {3'd3, 3'd5, 3'd7};
    endfunction

    task automatic model_write(input logic [31:0] a, d, input logic [3:0] s, output logic [1:0] resp);
        logic [3:0]  es;
        logic [31:0] old_w, new_w;
        es = s;
`ifndef UART_AXIL_WSTRB_EN
        es = 4'hF;
`endif
        old_w = 0;
        if (a[4:2] == 3'd0) old_w = {29'b0, m_cr1};
        if (a[4:2] == 3'd2) old_w = {16'b0, m_brr};
        for (int b = 0; b < 4; b++) new_w[8*b +: 8] = es[b] ? d[8*b +: 8] : old_w[8*b +: 8];
        case (a[4:2])
            3'd0: m_cr1 = new_w[2:0];
            3'd1: if (es[0] && d[3]) m_ore = 0;
            3'd2: m_brr = new_w[15:0];
            3'd6: if (es[0]) begin m_txd = d[7:0]; exp_tx_wr = 1; end
            default: ;
        endcase
        resp = unmapped(a) ? 2'b10 : 2'b00;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a[4:2])
            3'd0:    return {29'b0, m_cr1};
            3'd1:    return {28'b0, m_ore, 1'b0, m_rxne, ~tx_busy};
            3'd2:    return {16'b0, m_brr};
            3'd4:    return {24'b0, m_rdr};
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("cr1", cr1, m_cr1);
            chk("brr", brr, m_brr);
            chk("tx_data", tx_data, m_txd);
            chk("tx_wr", tx_wr, exp_tx_wr);
            exp_tx_wr = 0;
            chk("bvalid", axil.bvalid, exp_bvalid);
            if (exp_bvalid) chk("bresp", axil.bresp, exp_bresp);
            chk("rvalid", axil.rvalid, exp_rvalid);
            if (exp_rvalid) begin
                chk("rdata", axil.rdata, exp_rdata);
                chk("rresp", axil.rresp, exp_rresp);
            end
        end
    end

    task automatic axil_write(input logic [31:0] a, d, input logic [3:0] s,
                              input int aw_dly, w_dly, b_dly, output logic [1:0] resp);
        int cyc; bit aw_done, w_done, aw_hs, w_hs;
        logic [1:0] er;
        cyc = 0; aw_done = 0; w_done = 0; resp = 2'b11;
        axil.awaddr = a; axil.wdata = d; axil.wstrb = s;
        while (!(aw_done && w_done) && cyc < 40) begin
            axil.awvalid = !aw_done && cyc >= aw_dly;
            axil.wvalid  = !w_done && cyc >= w_dly;
            aw_hs = axil.awvalid && axil.awready;
            w_hs  = axil.wvalid && axil.wready;
            @(posedge Clk); #1; cyc++;
            aw_done |= aw_hs; w_done |= w_hs;
            chk("awready_hold", axil.awready, !aw_done);
            chk("wready_hold", axil.wready, !w_done);
        end
        axil.awvalid = 0; axil.wvalid = 0;
        chk("aw_w_accepted", aw_done && w_done, 1'b1);
        if (!(aw_done && w_done)) return;
        chk("bvalid_early", axil.bvalid, 1'b0);
        @(posedge Clk); #1;
        chk("bvalid_latency", axil.bvalid, 1'b1);
        chk("awready_free", axil.awready, 1'b1);
        model_write(a, d, s, er);
        exp_bvalid = 1; exp_bresp = er;
        resp = axil.bresp;
        repeat (b_dly) begin @(posedge Clk); #1; end
        axil.bready = 1;
        @(posedge Clk); #1;
        axil.bready = 0; exp_bvalid = 0;
    endtask

    task automatic axil_read(input logic [31:0] a, input int r_dly, input bit with_rx,
                             input logic [7:0] rx_byte, output logic [31:0] data, output logic [1:0] resp);
        int cyc; bit hs, hs_now, rxne_old;
        logic [31:0] ed;
        cyc = 0; hs = 0; ed = 0; data = 'x; resp = 'x;
        axil.araddr = a; axil.arvalid = 1;
        while (!hs && cyc < 20) begin
            hs_now = axil.arready;
            if (hs_now) begin
                ed = model_read(a);
                if (with_rx) begin rx_data = rx_byte; rx_valid = 1; end
            end
            @(posedge Clk); #1; cyc++;
            rx_valid = 0;
            hs = hs_now;
        end
        axil.arvalid = 0;
        chk("ar_handshake", hs, 1'b1);
        if (!hs) return;
        rxne_old = m_rxne;
        if (a[4:2] == 3'd4) m_rxne = 0;
        if (with_rx) begin m_ore = m_ore | rxne_old; m_rxne = 1; m_rdr = rx_byte; end
        exp_rvalid = 1; exp_rdata = ed; exp_rresp = unmapped(a) ? 2'b10 : 2'b00;
        chk("arready_busy", axil.arready, 1'b0);
        data = axil.rdata; resp = axil.rresp;
        repeat (r_dly) begin @(posedge Clk); #1; end
        axil.rready = 1;
        @(posedge Clk); #1;
        axil.rready = 0; exp_rvalid = 0;
        chk("arready_back", axil.arready, 1'b1);
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_data = b; rx_valid = 1;
        @(posedge Clk); #1;
        rx_valid = 0;
        if (m_rxne) m_ore = 1;
        m_rxne = 1; m_rdr = b;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_awready"}, axil.awready, 1'b0);
        chk({tag, "_wready"}, axil.wready, 1'b0);
        chk({tag, "_arready"}, axil.arready, 1'b0);
        chk({tag, "_bvalid"}, axil.bvalid, 1'b0);
        chk({tag, "_rvalid"}, axil.rvalid, 1'b0);
        chk({tag, "_bresp"}, axil.bresp, 2'b00);
        chk({tag, "_rresp"}, axil.rresp, 2'b00);
        chk({tag, "_rdata"}, axil.rdata, 32'h0);
        chk({tag, "_cr1"}, cr1, 3'b000);
        chk({tag, "_brr"}, brr, 16'h0364);
        chk({tag, "_tx_wr"}, tx_wr, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  r;
        Rst_n = 1; tx_busy = 0; rx_valid = 0; rx_data = 0; cmp_en = 0;
        axil.awaddr = 0; axil.awvalid = 0; axil.wdata = 0; axil.wstrb = 0; axil.wvalid = 0;
        axil.bready = 0; axil.araddr = 0; axil.arvalid = 0; axil.rready = 0;
        model_reset();
        #3 Rst_n = 0; cmp_en = 1;
        #1 check_reset_outputs("rst");
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1;
        chk("awready_at_release", axil.awready, 1'b0);
        @(posedge Clk); #1;
        chk("awready_live", axil.awready, 1'b1);
        chk("wready_live", axil.wready, 1'b1);
        chk("arready_live", axil.arready, 1'b1);

        // BRR write/read round trip
        axil_write(32'h08, 32'h0000_0364, 4'hF, 0, 0, 0, r);
        chk("brr_wr_bresp", r, 2'b00);
        chk("brr_val", brr, 16'h0364);
        axil_read(32'h08, 0, 0, 8'h0, rd, r);
        chk("brr_rdata", rd, 32'h0000_0364);
        chk("brr_rresp", r, 2'b00);

        // Partial-strobe BRR write
        axil_write(32'h08, 32'h0000_FFFF, 4'b0001, 0, 0, 0, r);
`ifdef UART_AXIL_WSTRB_EN
        chk("brr_strb", brr, 16'h03FF);
`else
        chk("brr_strb", brr, 16'hFFFF);
`endif

        // W three cycles ahead of AW to TDR
        axil_write(32'h18, 32'h0000_0055, 4'hF, 3, 0, 0, r);
        chk("tdr_tx_data", tx_data, 8'h55);

        // Receive path and overrun
        tx_busy = 0;
        rx_pulse(8'hA5);
        rx_pulse(8'h3C);
        axil_read(32'h04, 0, 0, 8'h0, rd, r);
        chk("sr_overrun", rd, 32'h0B);
        axil_read(32'h10, 0, 0, 8'h0, rd, r);
        chk("rdr_latest", rd, 32'h3C);
        axil_read(32'h04, 0, 0, 8'h0, rd, r);
        chk("sr_after_rdr", rd, 32'h09);
        axil_write(32'h04, 32'h08, 4'hF, 0, 0, 0, r);
        axil_read(32'h04, 0, 0, 8'h0, rd, r);
        chk("sr_ore_cleared", rd, 32'h01);

        // Unmapped addresses with stalled response channels
        axil_read(32'h14, 5, 0, 8'h0, rd, r);
        chk("unmapped_rresp", r, 2'b10);
        chk("unmapped_rdata", rd, 32'h0);
        axil_write(32'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0, 5, r);
        chk("unmapped_bresp", r, 2'b10);

        // RDR read colliding with a new byte
        rx_pulse(8'h11);
        axil_read(32'h10, 0, 1, 8'h22, rd, r);
        chk("rdr_old_on_collision", rd, 32'h11);
        axil_read(32'h10, 0, 0, 8'h0, rd, r);
        chk("rdr_new_after_collision", rd, 32'h22);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, d;
            a = $urandom;
            a[4:2] = 3'($urandom_range(0, 7));
            d = $urandom;
            tx_busy = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: axil_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                                       $urandom_range(0, 3), $urandom_range(0, 2), r);
                4, 5, 6, 7: axil_read(a, $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                                      8'($urandom), rd, r);
                default:    rx_pulse(8'($urandom));
            endcase
        end

        // Reset while an AW sits in its holding register
        axil.awaddr = 32'h08; axil.awvalid = 1;
        @(posedge Clk); #1;
        axil.awvalid = 0;
        chk("aw_held_before_reset", axil.awready, 1'b0);
        Rst_n = 0;
        model_reset();
        #1 check_reset_outputs("midrst");
        @(posedge Clk); #1;
        Rst_n = 1;
        @(posedge Clk); #1;
        axil_write(32'h00, 32'h7, 4'hF, 3, 0, 0, r);
        chk("post_reset_cr1", cr1, 3'b111);
        chk("post_reset_bresp", r, 2'b00);
        repeat (2) @(posedge Clk);
        #1;

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/uart_axil_regs.md
UART_AXIL_REGS -- requirements
Module: uart_axil_regs

Interface
REQ-001 Parameter ADDR_W, default 32, AXI-Lite address width; only addr[4:2] decoded.
REQ-002 Parameter DATA_W, default 32, AXI-Lite data width; fixed at 32, other values unsupported.
REQ-003 Parameter BRR_RST, default 16'h0364, BRR reset value.
REQ-004 Ports: Clk  in  1  sole clock, all logic rising-edge; Rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Ports: wr_axil  taxi_axil_if.wr_slv  --  AW/W/B channels; rd_axil  taxi_axil_if.rd_slv  --  AR/R channels.
REQ-006 Ports: cr1  out  3  {RE,TE,UE}; brr  out  16  baud divisor; tx_data  out  8  TDR contents; tx_wr  out  1  one-cycle pulse on each TDR write.
REQ-007 Ports: tx_busy  in  1  transmitter busy; rx_data  in  8  received byte; rx_valid  in  1  one-cycle pulse, rx_data valid.

Function
REQ-008 Register map: 0x00 CR1 RW [2:0]; 0x04 SR [0]TXE=~tx_busy RO, [1]RXNE RO, [3]ORE W1C; 0x08 BRR RW [15:0]; 0x10 RDR RO [7:0]; 0x18 TDR WO [7:0] (reads 0); unused bits read 0.
REQ-009 Unmapped address (0x0C, 0x14, 0x1C): write ignored, read data 0, resp SLVERR (2'b10); mapped access resp OKAY (2'b00); write to RO RDR: ignored, OKAY.
REQ-010 AW and W accepted independently, any order or same cycle; each latched in a one-entry holding register.
REQ-011 awready=1 iff AW holding empty; wready=1 iff W holding empty.
REQ-012 Write commits the cycle after both holdings full and bvalid=0; same edge asserts bvalid, clears both holdings.
REQ-013 bvalid held until bready; no new commit while bvalid=1; back-to-back writes sustain one per 2 cycles with bready tied high.
REQ-014 Read FSM: IDLE (arready=1) -> AR handshake -> RESP (rvalid=1, arready=0) -> rready -> IDLE; rdata/rresp registered, latency 1 cycle from AR handshake.
REQ-015 rdata/rresp stable while rvalid=1 and rready=0.
REQ-016 TDR write: tx_data updated and tx_wr=1 for exactly the commit cycle+1 edge (one Clk).
REQ-017 rx_valid: captures rx_data into RDR, sets RXNE; if RXNE already 1, also sets ORE and RDR overwritten.
REQ-018 RDR read clears RXNE on the AR handshake edge; simultaneous rx_valid wins: RXNE stays 1, RDR takes new byte, rdata returns old byte.
REQ-019 SR write: ORE cleared where wdata[3]=1; simultaneous overrun on same edge wins (ORE stays 1).
REQ-020 Read and write channels fully concurrent; read of a register committed same edge returns the old value.

Reset
REQ-021 Rst_n=0 asynchronously: cr1=0, brr=BRR_RST, tx_data=0, tx_wr=0, RDR=0, RXNE=0, ORE=0, holdings empty.
REQ-022 During reset: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0; readies rise on first Clk edge after Rst_n release.
REQ-023 Reset mid-transaction discards held AW/W and pending B/R responses; no tx_wr pulse emitted.

Configuration
REQ-024 Macro UART_AXIL_WSTRB_EN defined: wstrb honoured per byte lane for CR1, BRR, TDR, SR (strobe low = lane unchanged; TDR with wstrb[0]=0 produces no tx_wr).
REQ-025 Macro undefined: wstrb ignored, every write treated as 4'hF.

Verification
REQ-026 Write 0x08=0x00000364 then read 0x08 -> bresp OKAY, rdata 0x00000364, brr=16'h0364.
REQ-027 W issued 3 cycles before AW to 0x18 data 0x55 -> wready low after W accepted, single tx_wr pulse, tx_data=0x55, bvalid 1 cycle after AW.
REQ-028 rx_valid with 0xA5, second rx_valid with 0x3C, read 0x04 -> rdata 0x0B (TXE,RXNE,ORE); read 0x10 -> 0x3C; read 0x04 -> 0x09; write 0x04=0x08 -> SR 0x01.
REQ-029 Read 0x14 and write 0x1C -> rresp/bresp 2'b10, rdata 0, no register change; hold bready/rready low 5 cycles -> responses stable.
REQ-030 Assert Rst_n=0 while AW held without W -> after release, write 0x00=0x7 completes normally, cr1=3'b111, no stale commit.
REQ-031 With UART_AXIL_WSTRB_EN, write 0x08=0x0000FFFF wstrb 4'b0001 from brr 0x0364 -> brr 0x03FF; without macro -> brr 0xFFFF.
